pad_serializer_multi: RTL and testbench
=======================================

Name: pad_serializer_multi

Overview:
Parametrised successor to the single-port mock gamepad. It emulates N SNES-style serial gamepads from parallel button vectors, such as PCB buttons or USB-decoded buttons. Each player's buttons pass through a 2-flop synchronizer and a sampled debouncer, are parallel-loaded on pad_latch, and are shifted out on pad_clk rising edges. It sits between the board-level button sources and the ics32 pad_data inputs, in the clk_2x domain.

Parameters:
PLAYERS, 2, number of emulated pads; must be 1..4.
BUTTONS, 12, buttons per pad, shifted LSB first; must be 1..16.
DEBOUNCE_DIV, 16'd1024, clk cycles between debounce samples; must be ≥1.
FILL_VALUE, 1'b1, level shifted in once all BUTTONS bits have been shifted out.
SYNC_INPUTS, 1, 1 = pad_btn passes through a 2-flop synchronizer; 0 = used directly.

Ports:
clk  in  1  system clock (clk_2x domain).
reset  in  1  synchronous, active-high reset.
pad_btn  in  PLAYERS*BUTTONS  raw buttons, active-high; player p occupies bits [p*BUTTONS +: BUTTONS]; may be asynchronous.
pad_latch  in  1  level; high = load shift registers (synchronous to clk).
pad_clk  in  1  serial clock from host; data advances on its rising edge (synchronous to clk).
pad_out  out  PLAYERS  serial data, one bit per player; equals bit 0 of that player's shift register.
btn_state  out  PLAYERS*BUTTONS  debounced button state, for LEDs/debug.
shift_count  out  5  shifts since the last latch, saturating at 31.

Behaviour:
- Reset (sync, active-high): all of the following clear to 0 — sync flops, debounce divider, last samples, btn_state, shift registers, pad_clk edge register, shift_count. pad_out therefore reads 0.
- Synchronizer: when SYNC_INPUTS=1, two flops per bit, adding 2 cycles of latency. When SYNC_INPUTS=0, no added latency.
- Debounce divider:
  - A free-running counter counts 0..DEBOUNCE_DIV-1 and wraps.
  - tick = 1 for one cycle when the counter equals DEBOUNCE_DIV-1.
  - On tick, each bit's synced value is stored in last_sample.
  - On tick, btn_state[i] is updated to the synced value only if the synced value equals last_sample[i], i.e. two consecutive agreeing samples.
  - Worst-case press-to-btn_state latency: 2*DEBOUNCE_DIV + 2 (sync) + 1 cycles.
- pad_clk edge detect: registered pad_clk_q. rise = pad_clk & ~pad_clk_q. One shift per rising edge; a high level held for many cycles shifts exactly once.
- Shift register: per player, BUTTONS bits wide. Priority per cycle:
  1. pad_latch=1: load btn_state for that player (current registered value, same cycle) and set shift_count to 0. A simultaneous rise is ignored (load wins), but pad_clk_q still updates.
  2. Otherwise, on rise: shift right by one, insert FILL_VALUE at the MSB, and increment shift_count (saturating at 31).
  3. Otherwise: hold.
- pad_latch is level-sensitive. While held high, the register tracks btn_state continuously.
- Load and shift take effect at the next edge of clk. pad_out reflects the new bit 1 cycle after the latch or rise cycle.
- Wrap-around: after BUTTONS shifts, pad_out = FILL_VALUE for every further shift, indefinitely, until the next latch.
- btn_state changing mid-read does not disturb the shift registers until the next latch.
- Players share the latch, clock and divider; their data paths are independent.
- Reset asserted mid-read: pad_out goes to 0 on the next cycle. The register stays 0 until a latch, then behaves as after power-up.

Decomposition:
- Package pad_serializer_pkg holds:
  - constant SHIFT_COUNT_W = 5;
  - constant SHIFT_COUNT_MAX = 31;
  - the default DEBOUNCE_DIV.
- One sub-module, pad_debouncer: parametrised on WIDTH and DEBOUNCE_DIV, containing the sync flops, divider, last_sample and btn_state.
- The top instantiates one pad_debouncer of width PLAYERS*BUTTONS and generates PLAYERS shift registers.

Test Plan:
1. Reset behaviour. Parameters: PLAYERS=2, BUTTONS=12, DEBOUNCE_DIV=4. Assert reset for 3 cycles while pad_btn = all ones. Required: pad_out=2'b00, btn_state=0 and shift_count=0 during reset and on the first cycle after it.
2. Debounce and basic read.
   - Hold P1=12'hA5C and P2=12'h3F0 for 20 cycles; required: btn_state matches.
   - Pulse pad_latch for 1 cycle, then give 12 pad_clk pulses (2 cycles high, 2 low). Required: P1 pad_out sequence before each rise, LSB first = 0,0,1,1,1,0,1,0,0,1,0,1. P2 matches 12'h3F0 LSB first.
   - Required after the read: shift_count=12.
3. Fill/wrap. After test 2, give 5 more pad_clk pulses. Required: pad_out=2'b11 throughout, and shift_count=17. Then give 20 more pulses: shift_count saturates at 31.
4. Bounce rejection. DEBOUNCE_DIV=4. Toggle bit 0 every 3 cycles for 40 cycles. Required: btn_state[0] never changes. Then hold it at 1; required: btn_state[0]=1 within 2*4+3 cycles.
5. Latch/clock collision. Assert pad_latch and a pad_clk rise in the same cycle with P1=12'h001. Required: the register loads 12'h001, pad_out[0]=1 next cycle, and shift_count=0 (no shift). Hold pad_clk high for 10 cycles after dropping latch: exactly one shift occurs.
6. Reset mid-read with SYNC_INPUTS=0. After latching P1=12'hFFF and giving 3 shifts, assert reset for 1 cycle. Required: pad_out=0 and shift_count=0 the next cycle. The next latch plus 12 shifts returns 1 on every shift, but only once btn_state has re-debounced to 12'hFFF (≥2*DEBOUNCE_DIV cycles after reset).

Source files
------------

// File: rtl/pad_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pad_serializer_pkg
//  Description : Shared constants for the multi-player pad serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pad_serializer_pkg;

  // Width and saturation value of the shifts-since-latch counter
  localparam int                         SHIFT_COUNT_W   = 5;
  localparam logic [SHIFT_COUNT_W-1:0]   SHIFT_COUNT_MAX = 5'd31;

  // Default number of clk cycles between debounce samples
  localparam logic [15:0]                DEFAULT_DEBOUNCE_DIV = 16'd1024;

endpackage : pad_serializer_pkg
`default_nettype wire

// File: rtl/pad_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : pad_debouncer
//  Description : Optional 2-flop synchronizer followed by a sampled debouncer.
//                A bit is accepted only when two consecutive samples agree.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_debouncer
  import pad_serializer_pkg::*;
#(
  parameter int          WIDTH        = 24,
  parameter logic [15:0] DEBOUNCE_DIV = DEFAULT_DEBOUNCE_DIV,
  parameter bit          SYNC_INPUTS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] btn_state
);

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] last_sample;
  logic [WIDTH-1:0] agree;
  logic [15:0]      div_cnt;
  logic             tick;

  generate
    if (SYNC_INPUTS) begin : g_sync
      logic [WIDTH-1:0] meta;
      logic [WIDTH-1:0] stable;

      // Two-flop synchronizer for possibly asynchronous button inputs
      always_ff @(posedge clk) begin
        if (reset) begin
          meta   <= '0;
          stable <= '0;
        end else begin
          meta   <= raw;
          stable <= meta;
        end
      end

      assign synced = stable;
    end else begin : g_direct
      assign synced = raw;
    end
  endgenerate

  assign tick  = (div_cnt == (DEBOUNCE_DIV - 16'd1));
  assign agree = ~(synced ^ last_sample);

  // Free-running sample divider, wraps after DEBOUNCE_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // On each sample tick, accept bits whose last two samples agree
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample <= '0;
      btn_state   <= '0;
    end else if (tick) begin
      last_sample <= synced;
      btn_state   <= (agree & synced) | (~agree & btn_state);
    end
  end

endmodule : pad_debouncer
`default_nettype wire

// File: rtl/pad_serializer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pad_serializer_multi
//  Description : Emulates PLAYERS SNES-style serial gamepads. Debounced
//                buttons are parallel-loaded on pad_latch and shifted out
//                LSB first on each pad_clk rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_serializer_multi
  import pad_serializer_pkg::*;
#(
  parameter int          PLAYERS      = 2,
  parameter int          BUTTONS      = 12,
  parameter logic [15:0] DEBOUNCE_DIV = DEFAULT_DEBOUNCE_DIV,
  parameter logic        FILL_VALUE   = 1'b1,
  parameter bit          SYNC_INPUTS  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PLAYERS*BUTTONS-1:0] pad_btn,
  input  logic                       pad_latch,
  input  logic                       pad_clk,
  output logic [PLAYERS-1:0]         pad_out,
  output logic [PLAYERS*BUTTONS-1:0] btn_state,
  output logic [SHIFT_COUNT_W-1:0]   shift_count
);

  // Bit pattern OR-ed into the MSB on every shift
  localparam logic [BUTTONS-1:0] FILL_MASK =
    FILL_VALUE ? (BUTTONS'(1) << (BUTTONS - 1)) : '0;

  generate
    if (PLAYERS < 1 || PLAYERS > 4) begin : g_bad_players
      $error("pad_serializer_multi: PLAYERS must be 1..4");
    end
    if (BUTTONS < 1 || BUTTONS > 16) begin : g_bad_buttons
      $error("pad_serializer_multi: BUTTONS must be 1..16");
    end
    if (DEBOUNCE_DIV < 16'd1) begin : g_bad_div
      $error("pad_serializer_multi: DEBOUNCE_DIV must be >= 1");
    end
  endgenerate

  logic pad_clk_q;
  logic rise;

  pad_debouncer #(
    .WIDTH        (PLAYERS*BUTTONS),
    .DEBOUNCE_DIV (DEBOUNCE_DIV),
    .SYNC_INPUTS  (SYNC_INPUTS)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .raw       (pad_btn),
    .btn_state (btn_state)
  );

  assign rise = pad_clk & ~pad_clk_q;

  // Edge register for the host serial clock; updates even during a latch
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_clk_q <= 1'b0;
    end else begin
      pad_clk_q <= pad_clk;
    end
  end

  // Shifts since the last latch, saturating so long reads never wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_count <= '0;
    end else if (pad_latch) begin
      shift_count <= '0;
    end else if (rise && (shift_count != SHIFT_COUNT_MAX)) begin
      shift_count <= shift_count + 1'b1;
    end
  end

  generate
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [BUTTONS-1:0] shift_reg;

      // Load wins over shift; a shift moves data toward bit 0 and refills the MSB
      always_ff @(posedge clk) begin
        if (reset) begin
          shift_reg <= '0;
        end else if (pad_latch) begin
          shift_reg <= btn_state[p*BUTTONS +: BUTTONS];
        end else if (rise) begin
          shift_reg <= (shift_reg >> 1) | FILL_MASK;
        end
      end

      assign pad_out[p] = shift_reg[0];
    end
  endgenerate

endmodule : pad_serializer_multi
`default_nettype wire

// File: tb/tb_pad_serializer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pad_serializer_multi
//  Description : Self-checking bench for pad_serializer_multi. Two instances
//                (synchronized and direct inputs) share all stimulus and are
//                compared every cycle against a behavioural model, plus
//                directed checks of the read sequence and corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_serializer_multi;

  localparam int   PLAYERS = 2;
  localparam int   BUTTONS = 12;
  localparam int   DIV     = 4;
  localparam int   W       = PLAYERS * BUTTONS;
  localparam logic FILL    = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic         pad_latch;
  logic         pad_clk;
  logic [W-1:0] pad_btn;

  logic [PLAYERS-1:0] out_s, out_d;
  logic [W-1:0]       btn_s, btn_d;
  logic [4:0]         cnt_s, cnt_d;

  int n_checks;
  int n_fail;

  // Model state: index 0 = synchronized instance, 1 = direct instance
  int                 m_n;
  logic [W-1:0]       h1, h2;
  logic [W-1:0]       m_btn  [2];
  logic [W-1:0]       m_last [2];
  logic [BUTTONS-1:0] m_word [2][PLAYERS];
  int                 m_shifts [2];
  logic               m_prev_clk;

  always #5 clk = ~clk;

  pad_serializer_multi #(
    .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .DEBOUNCE_DIV(16'd4),
    .FILL_VALUE(FILL), .SYNC_INPUTS(1'b1)
  ) dut_sync (
    .clk(clk), .reset(reset), .pad_btn(pad_btn), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .pad_out(out_s), .btn_state(btn_s), .shift_count(cnt_s)
  );

  pad_serializer_multi #(
    .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .DEBOUNCE_DIV(16'd4),
    .FILL_VALUE(FILL), .SYNC_INPUTS(1'b0)
  ) dut_direct (
    .clk(clk), .reset(reset), .pad_btn(pad_btn), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .pad_out(out_d), .btn_state(btn_d), .shift_count(cnt_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: samples every DIV cycles, word + read index per player
  task automatic model_edge();
    logic         rise;
    logic [W-1:0] synced;
    if (reset) begin
      m_n        = 0;
      m_prev_clk = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_btn[d]    = '0;
        m_last[d]   = '0;
        m_shifts[d] = 0;
        for (int p = 0; p < PLAYERS; p++) m_word[d][p] = '0;
      end
    end else begin
      m_n++;
      rise = pad_clk && !m_prev_clk;
      for (int d = 0; d < 2; d++) begin
        if (pad_latch) begin
          for (int p = 0; p < PLAYERS; p++) m_word[d][p] = m_btn[d][p*BUTTONS +: BUTTONS];
          m_shifts[d] = 0;
        end else if (rise) begin
          m_shifts[d]++;
        end
        if (d == 1) synced = pad_btn;
        else        synced = (m_n >= 3) ? h2 : '0;
        if (m_n % DIV == 0) begin
          for (int b = 0; b < W; b++)
            if (synced[b] == m_last[d][b]) m_btn[d][b] = synced[b];
          m_last[d] = synced;
        end
      end
      m_prev_clk = pad_clk;
    end
    h2 = h1;
    h1 = pad_btn;
  endtask

  task automatic compare_all();
    logic [PLAYERS-1:0] exp_out [2];
    int                 exp_cnt [2];
    for (int d = 0; d < 2; d++) begin
      exp_cnt[d] = (m_shifts[d] > 31) ? 31 : m_shifts[d];
      for (int p = 0; p < PLAYERS; p++)
        exp_out[d][p] = (m_shifts[d] < BUTTONS) ? m_word[d][p][m_shifts[d]] : FILL;
    end
    check("model_btn_sync",   btn_s, m_btn[0]);
    check("model_btn_direct", btn_d, m_btn[1]);
    check("model_out_sync",   out_s, exp_out[0]);
    check("model_out_direct", out_d, exp_out[1]);
    check("model_cnt_sync",   cnt_s, exp_cnt[0]);
    check("model_cnt_direct", cnt_d, exp_cnt[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // One host clock pulse, checking pad_out just before the rise
  task automatic pulse(input string tag, input logic [PLAYERS-1:0] exp_before);
    check({tag, "_sync"},   out_s, exp_before);
    check({tag, "_direct"}, out_d, exp_before);
    pad_clk = 1'b1;
    step(); step();
    pad_clk = 1'b0;
    step(); step();
  endtask

  initial begin
    logic [BUTTONS-1:0] p1, p2;
    logic [BUTTONS-1:0] rnd;
    n_checks   = 0;
    n_fail     = 0;
    m_n        = 0;
    m_prev_clk = 1'b0;
    h1         = '0;
    h2         = '0;
    for (int d = 0; d < 2; d++) begin
      m_btn[d] = '0; m_last[d] = '0; m_shifts[d] = 0;
      for (int p = 0; p < PLAYERS; p++) m_word[d][p] = '0;
    end

    // Reset with all buttons pressed
    reset = 1'b1; pad_latch = 1'b0; pad_clk = 1'b0; pad_btn = '1;
    repeat (3) begin
      step();
      check("rst_out", {out_s, out_d}, 4'b0000);
      check("rst_btn", btn_s | btn_d, 0);
      check("rst_cnt", {cnt_s, cnt_d}, 0);
    end
    reset = 1'b0;
    p1 = 12'hA5C; p2 = 12'h3F0;
    pad_btn = {p2, p1};
    step();
    check("post_rst_out", {out_s, out_d}, 4'b0000);
    check("post_rst_btn", btn_s | btn_d, 0);
    check("post_rst_cnt", {cnt_s, cnt_d}, 0);

    // Debounce then a full 12-bit read
    repeat (19) step();
    check("dbnc_sync",   btn_s, {12'h3F0, 12'hA5C});
    check("dbnc_direct", btn_d, {12'h3F0, 12'hA5C});
    pad_latch = 1'b1; step(); pad_latch = 1'b0;
    for (int i = 0; i < BUTTONS; i++) pulse("read_bit", {p2[i], p1[i]});
    check("read_cnt_sync",   cnt_s, 12);
    check("read_cnt_direct", cnt_d, 12);

    // Fill level after the buttons are exhausted, then saturation
    for (int i = 0; i < 5; i++) pulse("fill_bit", 2'b11);
    check("fill_out", out_s, 2'b11);
    check("fill_cnt", cnt_s, 17);
    for (int i = 0; i < 20; i++) pulse("sat_bit", 2'b11);
    check("sat_cnt_sync",   cnt_s, 31);
    check("sat_cnt_direct", cnt_d, 31);

    // Bounce on bit 0 (currently debounced 0); align so no two 1-samples agree
    if (m_n % 2 != 0) step();
    for (int i = 0; i < 40; i++) begin
      pad_btn[0] = ((i / 3) % 2 == 0);
      step();
      check("bounce_sync",   btn_s[0], 1'b0);
      check("bounce_direct", btn_d[0], 1'b0);
    end
    pad_btn[0] = 1'b1;
    repeat (2*DIV + 3) step();
    check("hold_sync",   btn_s[0], 1'b1);
    check("hold_direct", btn_d[0], 1'b1);

    // Latch and rise in the same cycle: load wins, no shift
    pad_btn[BUTTONS-1:0] = 12'h001;
    repeat (12) step();
    check("p1_001", btn_s[BUTTONS-1:0], 12'h001);
    pad_latch = 1'b1; pad_clk = 1'b1;
    step();
    check("coll_cnt", {cnt_s, cnt_d}, 0);
    check("coll_out", {out_s[0], out_d[0]}, 2'b11);
    pad_latch = 1'b0;
    step(); step();
    check("coll_held_cnt", {cnt_s, cnt_d}, 0);
    pad_clk = 1'b0; step();
    pad_clk = 1'b1;
    repeat (10) step();
    check("one_shift_cnt", {cnt_s, cnt_d}, {5'd1, 5'd1});
    check("one_shift_out", {out_s[0], out_d[0]}, 2'b00);
    pad_clk = 1'b0; step();

    // Random patterns on both players, read against the model
    for (int k = 0; k < 3; k++) begin
      rnd = BUTTONS'($urandom);
      p1  = rnd;
      rnd = BUTTONS'($urandom);
      p2  = rnd;
      pad_btn = {p2, p1};
      repeat (2*DIV + 4) step();
      pad_latch = 1'b1; step(); pad_latch = 1'b0;
      for (int i = 0; i < BUTTONS + 2; i++)
        pulse("rand_bit", (i < BUTTONS) ? {p2[i], p1[i]} : 2'b11);
    end

    // Reset in the middle of a read
    pad_btn[BUTTONS-1:0] = 12'hFFF;
    repeat (12) step();
    check("fff_direct", btn_d[BUTTONS-1:0], 12'hFFF);
    pad_latch = 1'b1; step(); pad_latch = 1'b0;
    for (int i = 0; i < 3; i++) pulse("pre_rst_bit", {p2[i], 1'b1});
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_out", {out_s, out_d}, 4'b0000);
    check("midrst_cnt", {cnt_s, cnt_d}, 0);
    repeat (2*DIV + 4) step();
    check("redbnc_direct", btn_d[BUTTONS-1:0], 12'hFFF);
    check("redbnc_sync",   btn_s[BUTTONS-1:0], 12'hFFF);
    pad_latch = 1'b1; step(); pad_latch = 1'b0;
    for (int i = 0; i < BUTTONS; i++) begin
      check("reread_sync",   out_s[0], 1'b1);
      check("reread_direct", out_d[0], 1'b1);
      pulse("reread_bit", {p2[i], 1'b1});
    end
    check("reread_cnt", {cnt_s, cnt_d}, {5'd12, 5'd12});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pad_serializer_multi
`default_nettype wire
